hilo_ctrl: RTL and testbench

- Parametrised HI/LO special-register block for the 5-stage pipeline CPU.
- Holds the 2×XLEN result of the multi-cycle mult/div unit. Serves mfhi/mflo reads and mthi/mtlo writes.
- Tracks an in-flight mult/div operation with a tagged handshake.
- Raises a pipeline stall when a HI/LO access collides with a pending result. Discards results of flushed operations.

---
 rtl/hilo_pkg.sv | 20 ++
 rtl/hilo_tag_tracker.sv | 59 +++++
 rtl/hilo_ctrl.sv | 100 ++++++++++
 tb/tb_hilo_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO special-register block: read selects,
// tracker state and mthi/mtlo write-enable bit positions.
package hilo_pkg;

    localparam int unsigned RD_SEL_W = 2;
    localparam int unsigned MT_WE_W  = 2;

    localparam logic [RD_SEL_W-1:0] RD_NONE = 2'b00;
    localparam logic [RD_SEL_W-1:0] RD_LO   = 2'b01;
    localparam logic [RD_SEL_W-1:0] RD_HI   = 2'b10;

    localparam int unsigned MT_LO_BIT = 0;
    localparam int unsigned MT_HI_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/hilo_tag_tracker.sv
// Tracks the single in-flight mult/div operation: busy flag, tag counter,
// and acceptance of the matching (non-flushed) result.
module hilo_tag_tracker
    import hilo_pkg::*;
#(
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             flush,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    output logic             op_ready,
    output logic [TAG_W-1:0] issue_tag,
    output logic             accept
);

    hilo_state_e      state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    // Flush takes priority over a matching result arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_start) begin
                    state_d = BUSY;
                    tag_d   = tag_q + TAG_W'(1);
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (res_valid && (res_tag == tag_q)) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_ready  = (state_q == IDLE);
    assign issue_tag = tag_q + TAG_W'(1);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register block: stores mult/div results, serves mfhi/mflo/mthi/mtlo
// and stalls accesses that collide with a pending result.
// Optional macro HILO_BYPASS_EN forwards a result arriving this cycle to reads.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_start,
    output logic                op_ready,
    output logic [TAG_W-1:0]    issue_tag,
    input  logic                flush,
    input  logic                res_valid,
    input  logic [TAG_W-1:0]    res_tag,
    input  logic [2*XLEN-1:0]   res_data,
    input  logic [MT_WE_W-1:0]  mt_we,
    input  logic [XLEN-1:0]     mt_data,
    input  logic [RD_SEL_W-1:0] rd_sel,
    output logic [XLEN-1:0]     rd_data,
    output logic                stall,
    output logic [XLEN-1:0]     hi_out,
    output logic [XLEN-1:0]     lo_out
);

    logic            accept;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] rd_hi, rd_lo;
    logic            rd_blocked;

    hilo_tag_tracker #(
        .TAG_W (TAG_W)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .flush     (flush),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .op_ready  (op_ready),
        .issue_tag (issue_tag),
        .accept    (accept)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // mthi/mtlo only land while idle; an accepted result only lands while busy.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_ready) begin
            if (mt_we[MT_HI_BIT]) hi_d = mt_data;
            if (mt_we[MT_LO_BIT]) lo_d = mt_data;
        end else if (accept) begin
            hi_d = res_data[2*XLEN-1:XLEN];
            lo_d = res_data[XLEN-1:0];
        end
    end

    always_comb begin
        rd_hi      = hi_q;
        rd_lo      = lo_q;
        rd_blocked = (rd_sel != RD_NONE);
`ifdef HILO_BYPASS_EN
        if (accept) begin
            rd_hi      = res_data[2*XLEN-1:XLEN];
            rd_lo      = res_data[XLEN-1:0];
            rd_blocked = 1'b0;
        end
`endif
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            RD_HI:   rd_data = rd_hi;
            RD_LO:   rd_data = rd_lo;
            default: rd_data = '0;
        endcase
    end

    // Writes and new issues always wait out a pending op, even with forwarding.
    assign stall = !op_ready && !flush &&
                   (rd_blocked || (mt_we != '0) || op_start);

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized and directed bench for hilo_ctrl against a cycle-level model.
module tb_hilo_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 2;
    localparam int          NTAGS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              op_start;
    logic              op_ready;
    logic [TAG_W-1:0]  issue_tag;
    logic              flush;
    logic              res_valid;
    logic [TAG_W-1:0]  res_tag;
    logic [2*XLEN-1:0] res_data;
    logic [1:0]        mt_we;
    logic [XLEN-1:0]   mt_data;
    logic [1:0]        rd_sel;
    logic [XLEN-1:0]   rd_data;
    logic              stall;
    logic [XLEN-1:0]   hi_out;
    logic [XLEN-1:0]   lo_out;

    hilo_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .op_ready  (op_ready),
        .issue_tag (issue_tag),
        .flush     (flush),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .mt_we     (mt_we),
        .mt_data   (mt_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .stall     (stall),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: two numbers, a pending flag and the tag of the pending op.
    longint unsigned m_hi, m_lo;
    bit              m_pending;
    int              m_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet();
        reset = 0; op_start = 0; flush = 0; res_valid = 0; res_tag = '0;
        res_data = '0; mt_we = '0; mt_data = '0; rd_sel = '0;
    endtask

    // Inputs are already applied; check combinational view, then clock and advance model.
    task automatic cyc();
        bit              hit;
        bit              exp_stall;
        longint unsigned src_hi, src_lo, exp_rd;
        #1;
        hit       = m_pending && res_valid && (int'(res_tag) == m_tag) && !flush;
        exp_stall = m_pending && !flush && (rd_sel != 0 || mt_we != 0 || op_start);
        src_hi    = m_hi;
        src_lo    = m_lo;
`ifdef HILO_BYPASS_EN
        if (hit) begin
            src_hi = res_data >> XLEN;
            src_lo = res_data % (64'd1 << XLEN);
            if (mt_we == 0 && !op_start) exp_stall = 0;
        end
`endif
        if (rd_sel == 2'b10)      exp_rd = src_hi;
        else if (rd_sel == 2'b01) exp_rd = src_lo;
        else                      exp_rd = 0;
        check("stall",     64'(stall),     64'(exp_stall));
        check("rd_data",   64'(rd_data),   exp_rd);
        check("op_ready",  64'(op_ready),  64'(!m_pending));
        check("issue_tag", 64'(issue_tag), 64'((m_tag + 1) % NTAGS));
        check("hi_out",    64'(hi_out),    m_hi);
        check("lo_out",    64'(lo_out),    m_lo);
        @(posedge clk);
        if (reset) begin
            m_hi = 0; m_lo = 0; m_pending = 0; m_tag = 0;
        end else if (!m_pending) begin
            if (mt_we[1]) m_hi = mt_data;
            if (mt_we[0]) m_lo = mt_data;
            if (op_start) begin
                m_pending = 1;
                m_tag     = (m_tag + 1) % NTAGS;
            end
        end else if (flush) begin
            m_pending = 0;
        end else if (hit) begin
            m_hi      = res_data >> XLEN;
            m_lo      = res_data % (64'd1 << XLEN);
            m_pending = 0;
        end
        #1;
        quiet();
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        m_hi = 0; m_lo = 0; m_pending = 0; m_tag = 0;
    endtask

    initial begin
        int exp_tags[5] = '{1, 2, 3, 0, 1};
        do_reset();
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_rd", 64'(rd_data), 64'd0);

        mt_we = 2'b01; mt_data = 32'h1234; cyc();
        check("mtlo", 64'(lo_out), 64'h1234);

        op_start = 1; cyc();
        rd_sel = 2'b10; cyc();
        rd_sel = 2'b10; res_valid = 1; res_tag = 2'd1; res_data = {32'd3, 32'd7}; cyc();
        check("res_hi", 64'(hi_out), 64'd3);
        check("res_lo", 64'(lo_out), 64'd7);
        rd_sel = 2'b10; cyc();

        op_start = 1; cyc();
        flush = 1; cyc();
        res_valid = 1; res_tag = 2'(m_tag); res_data = '1; cyc();
        check("flush_hi", 64'(hi_out), 64'd3);
        check("flush_ready", 64'(op_ready), 64'd1);

        op_start = 1; cyc();
        res_valid = 1; res_tag = 2'(m_tag + 1); res_data = 64'hDEAD; rd_sel = 2'b01; cyc();
        check("stale_busy", 64'(op_ready), 64'd0);
        rd_sel = 2'b01; cyc();
        res_valid = 1; res_tag = 2'(m_tag); res_data = {32'd0, 32'hA5}; rd_sel = 2'b01; cyc();
        check("late_lo", 64'(lo_out), 64'hA5);

        op_start = 1; flush = 1; res_valid = 1; res_tag = 2'(m_tag); cyc();
        flush = 1; res_valid = 1; res_tag = 2'(m_tag); res_data = '1; cyc();
        mt_we = 2'b11; mt_data = 32'h5555_AAAA; cyc();
        mt_we = 2'b10; mt_data = 32'h1; op_start = 1; cyc();
        mt_we = 2'b01; mt_data = 32'h2; cyc();
        check("busy_mt_blocked", 64'(lo_out), 64'h5555_AAAA);
        rd_sel = 2'b11; res_valid = 1; res_tag = 2'(m_tag); res_data = {32'h11, 32'h22}; cyc();

        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("wrap_tag", 64'(issue_tag), 64'(exp_tags[i]));
            op_start = 1; cyc();
            res_valid = 1; res_tag = 2'(exp_tags[i]); res_data = {$urandom, $urandom}; cyc();
            check("wrap_accept", 64'(op_ready), 64'd1);
        end

        op_start = 1; cyc();
        reset = 1; cyc();
        res_valid = 1; res_tag = 2'd1; res_data = '1; cyc();
        check("rst_mid_hi", 64'(hi_out), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            op_start  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            res_valid = ($urandom_range(0, 2) == 0);
            res_tag   = ($urandom_range(0, 3) != 0) ? 2'(m_tag) : 2'($urandom);
            res_data  = {$urandom, $urandom};
            mt_we     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            mt_data   = $urandom;
            rd_sel    = 2'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
